// File: rtl/fb_fetch_master.sv
// fb_fetch_master
//   Fetches a frame of words from memory over Wishbone as a series of bursts
//   and pushes each returned word into a downstream synchronous FIFO.
//   A burst only starts when the FIFO has room for all of its words.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   frame_start         one-cycle pulse; starts a fetch when frame_words != 0
//   base_addr           first word address of the frame
//   frame_words         number of words in the frame
//   wb_adr_o/cyc/stb    Wishbone master request
//   wb_cti_o            Wishbone cycle type identifier
//   wb_dat_i/ack/err    Wishbone master response
//   fifo_data/wr_en     registered FIFO write port
//   fifo_level          current FIFO occupancy
//   busy                frame in progress
//   err                 sticky bus error, cleared by the next accepted frame
//   dbg_state           current FSM state (IDLE=0, CHECK=1, BURST=2)
//
// Handshake: during BURST the master holds wb_cyc_o/wb_stb_o high and
//   wb_adr_o stable; a beat completes on any clock edge where wb_ack_i is
//   high (the word on wb_dat_i is taken) or wb_err_i is high (beat
//   discarded, cycle aborted). Responses outside BURST are ignored.
//
// Build option: define FB_FETCH_CTI_EN to drive incrementing-burst cycle
//   type identifiers (010 per beat, 111 on the last beat); otherwise the
//   master runs classic cycles with wb_cti_o = 000.

module fb_fetch_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [ADDR_WIDTH-1:0]       frame_words,
  output logic [ADDR_WIDTH-1:0]       wb_adr_o,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic [2:0]                  wb_cti_o,
  input  logic [DATA_WIDTH-1:0]       wb_dat_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_wr_en,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        err,
  output logic [1:0]                  dbg_state
);

  localparam int LENW  = $clog2(BURST_LEN) + 1;
  localparam int BEATW = $clog2(BURST_LEN);
  localparam int USEDW = $clog2(FIFO_DEPTH) + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] pend_base;
  logic [ADDR_WIDTH-1:0] pend_words;
  logic                  pend;
  logic [LENW-1:0]       burst_len;
  logic [BEATW-1:0]      beat;

  logic                  accept;
  logic                  ack_beat;
  logic                  bus_err;
  logic                  last_beat;
  logic                  room_ok;
  logic [LENW-1:0]       chk_len;
  logic [USEDW-1:0]      used;

  always_comb begin
    state_d   = state;
    accept    = frame_start && (frame_words != '0);
    bus_err   = (state == BURST) && wb_err_i;
    // An error on the same edge as an ack wins: the beat is discarded.
    ack_beat  = (state == BURST) && wb_ack_i && !wb_err_i;
    last_beat = (beat == BEATW'(burst_len - LENW'(1)));
    chk_len   = (remaining < ADDR_WIDTH'(BURST_LEN)) ? LENW'(remaining)
                                                     : LENW'(BURST_LEN);
    // A write registered this cycle is not yet in fifo_level, so count it.
    used      = USEDW'(fifo_level) + USEDW'(fifo_wr_en);
    room_ok   = (32'(used) + 32'(chk_len)) <= 32'(FIFO_DEPTH);

    case (state)
      IDLE:  if (accept) state_d = CHECK;
      CHECK: if (!accept && room_ok) state_d = BURST;
      BURST: begin
        if (bus_err) begin
          state_d = IDLE;
        end else if (ack_beat && last_beat) begin
          // A restart (now or pending) overrides the end of the frame.
          if (accept || pend || (remaining != ADDR_WIDTH'(burst_len)))
            state_d = CHECK;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wb_cyc_o  = (state == BURST);
    wb_stb_o  = (state == BURST);
    wb_adr_o  = (state == BURST) ? addr : '0;
    busy      = (state != IDLE);
    dbg_state = state;
`ifdef FB_FETCH_CTI_EN
    wb_cti_o  = (state != BURST) ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
`else
    wb_cti_o  = 3'b000;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      pend       <= 1'b0;
      pend_base  <= '0;
      pend_words <= '0;
      burst_len  <= '0;
      beat       <= '0;
      err        <= 1'b0;
      fifo_data  <= '0;
      fifo_wr_en <= 1'b0;
    end else begin
      state      <= state_d;
      fifo_wr_en <= ack_beat;
      if (ack_beat) fifo_data <= wb_dat_i;

      case (state)
        IDLE: begin
          if (accept) begin
            addr      <= base_addr;
            remaining <= frame_words;
            err       <= 1'b0;
          end
        end
        CHECK: begin
          if (accept) begin
            addr      <= base_addr;
            remaining <= frame_words;
            err       <= 1'b0;
          end else if (room_ok) begin
            burst_len <= chk_len;
            beat      <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            pend       <= 1'b1;
            pend_base  <= base_addr;
            pend_words <= frame_words;
            err        <= 1'b0;
          end
          if (bus_err) begin
            err  <= 1'b1;
            pend <= 1'b0;
          end else if (ack_beat) begin
            addr <= addr + ADDR_WIDTH'(1);
            beat <= beat + BEATW'(1);
            if (last_beat) begin
              pend <= 1'b0;
              // A pulse on this very edge is newer than any pending one.
              if (accept) begin
                addr      <= base_addr;
                remaining <= frame_words;
              end else if (pend) begin
                addr      <= pend_base;
                remaining <= pend_words;
              end else begin
                remaining <= remaining - ADDR_WIDTH'(burst_len);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fetch_master.sv
// tb_fb_fetch_master
//   Randomized self-checking bench for fb_fetch_master. A Wishbone slave
//   returns a hashed word per address; a reference model lists, per frame,
//   the expected addresses, FIFO words and burst sizes.

module tb_fb_fetch_master;

  localparam int DW = 32;
  localparam int AW = 24;
  localparam int BL = 8;
  localparam int FD = 64;

  logic          clk;
  logic          rst;
  logic          frame_start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] frame_words;
  logic [AW-1:0] wb_adr_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [DW-1:0] fifo_data;
  logic          fifo_wr_en;
  logic [6:0]    fifo_level;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;

  fb_fetch_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .base_addr(base_addr), .frame_words(frame_words),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en), .fifo_level(fifo_level),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_adr_q[$];
  int            exp_burst_q[$];

  // slave / monitor controls
  bit            mon_en;
  bit            stray;
  int            ack_pct;
  int            err_at;
  int            beats_in_frame;
  int            beat_cnt;
  bit            in_burst;
  bit            burst_err;
  bit            cyc_chk_pending;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference model: a frame is words base..base+n-1 (mod 2^AW) in bursts
  // of at most BL.
  task automatic plan_frame(input logic [AW-1:0] base, input int words);
    logic [AW-1:0] a;
    int rem;
    for (int i = 0; i < words; i++) begin
      a = base + AW'(i);
      exp_adr_q.push_back(a);
      exp_q.push_back(mem_word(a));
    end
    rem = words;
    while (rem > 0) begin
      exp_burst_q.push_back(rem > BL ? BL : rem);
      rem -= BL;
    end
  endtask

  // ---------------- slave + monitor ----------------
  task automatic slave_monitor();
    logic [DW-1:0] d;
    int plan;
    forever begin
      @(negedge clk);
      if (cyc_chk_pending) begin
        chk("cyc_after_err", wb_cyc_o, 0);
        cyc_chk_pending = 0;
      end
      if (fifo_wr_en && mon_en) begin
        if (exp_q.size() == 0) chk("fifo_unexpected", 1, 0);
        else begin
          d = exp_q.pop_front();
          chk("fifo_data", fifo_data, d);
        end
      end
      if (!mon_en) begin
        in_burst = 0;
        beat_cnt = 0;
      end else if (wb_cyc_o) begin
        if (!in_burst) begin
          in_burst  = 1;
          beat_cnt  = 0;
          burst_err = 0;
        end
        chk("stb", wb_stb_o, 1);
        plan = (exp_burst_q.size() > 0) ? exp_burst_q[0] : 0;
`ifdef FB_FETCH_CTI_EN
        chk("cti", wb_cti_o, (beat_cnt == plan - 1) ? 64'd7 : 64'd2);
`else
        chk("cti", wb_cti_o, 0);
`endif
      end else begin
        if (in_burst) begin
          if (exp_burst_q.size() == 0) chk("burst_unexpected", 1, 0);
          else begin
            plan = exp_burst_q.pop_front();
            chk("burst_len", beat_cnt, burst_err ? err_at - 1 : plan);
          end
          in_burst = 0;
        end
        chk("cti_idle", wb_cti_o, 0);
      end
      wb_ack_i = 0;
      wb_err_i = 0;
      if (wb_cyc_o && wb_stb_o) begin
        if ($urandom_range(99) < ack_pct) begin
          beats_in_frame++;
          if (beats_in_frame == err_at) begin
            wb_err_i        = 1;
            wb_dat_i        = $urandom;
            burst_err       = 1;
            cyc_chk_pending = 1;
          end else begin
            wb_ack_i = 1;
            wb_dat_i = mem_word(wb_adr_o);
            if (mon_en) begin
              if (exp_adr_q.size() == 0) chk("adr_unexpected", 1, 0);
              else chk("adr", wb_adr_o, exp_adr_q.pop_front());
            end
            beat_cnt++;
          end
        end
      end else if (stray) begin
        wb_ack_i = 1;
        wb_err_i = 1;
        wb_dat_i = $urandom;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_frame(input logic [AW-1:0] base, input int words);
    base_addr   = base;
    frame_words = AW'(words);
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int words);
    beats_in_frame = 0;
    @(posedge clk); #1;
    pulse_frame(base, words);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle_timeout"}, busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_data_left"}, exp_q.size(), 0);
    chk({tag, "_adr_left"}, exp_adr_q.size(), 0);
    chk({tag, "_burst_left"}, exp_burst_q.size(), 0);
  endtask

  task automatic wait_beat(input int target, input int budget);
    int n = 0;
    while (!(wb_cyc_o && beat_cnt >= target) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_beat_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] b;
    int w;
    int n;
    rst = 1; frame_start = 0; base_addr = 0; frame_words = 0;
    wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; fifo_level = 0;
    mon_en = 1; stray = 0; ack_pct = 100; err_at = 0; beats_in_frame = 0;
    beat_cnt = 0; in_burst = 0; burst_err = 0; cyc_chk_pending = 0;
    fork
      slave_monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cti", wb_cti_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 0;

    // 20-word frame, ack every cycle: bursts 8, 8, 4
    plan_frame(24'h000400, 20);
    start_frame(24'h000400, 20);
    chk("t20_busy_on", busy, 1);
    wait_idle("t20", 500);
    check_drained("t20");

    // FIFO nearly full holds the fetch in CHECK; stray responses ignored
    fifo_level = 7'd60;
    plan_frame(24'h001000, 8);
    start_frame(24'h001000, 8);
    stray = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("full_cyc", wb_cyc_o, 0);
      chk("full_busy", busy, 1);
      chk("full_wr_en", fifo_wr_en, 0);
      chk("full_err", err, 0);
    end
    stray = 0;
    fifo_level = 7'd56;
    @(posedge clk); #1;
    chk("room_cyc", wb_cyc_o, 1);
    wait_idle("room", 500);
    check_drained("room");
    fifo_level = 0;

    // stray responses while idle
    stray = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_stray_wr", fifo_wr_en, 0);
      chk("idle_stray_err", err, 0);
    end
    stray = 0;

    // bus error on beat 3
    err_at = 3;
    exp_adr_q.push_back(24'h002000);
    exp_adr_q.push_back(24'h002001);
    exp_q.push_back(mem_word(24'h002000));
    exp_q.push_back(mem_word(24'h002001));
    exp_burst_q.push_back(8);
    start_frame(24'h002000, 20);
    wait_idle("err", 500);
    chk("err_set", err, 1);
    chk("err_busy", busy, 0);
    check_drained("err");
    err_at = 0;
    plan_frame(24'h002100, 3);
    start_frame(24'h002100, 3);
    chk("err_clear", err, 0);
    wait_idle("err2", 500);
    check_drained("err2");

    // restart mid-burst: current burst completes, then new base
    plan_frame(24'h000800, 8);
    plan_frame(24'h000100, 5);
    start_frame(24'h000800, 16);
    wait_beat(3, 50);
    pulse_frame(24'h000100, 5);
    wait_idle("midrestart", 500);
    check_drained("midrestart");

    // restart on the final ack of a frame
    plan_frame(24'h003000, 8);
    plan_frame(24'h003100, 4);
    start_frame(24'h003000, 8);
    wait_beat(7, 50);
    pulse_frame(24'h003100, 4);
    wait_idle("lastack", 500);
    check_drained("lastack");

    // address wrap
    plan_frame(24'hFFFFFE, 4);
    start_frame(24'hFFFFFE, 4);
    wait_idle("wrap", 500);
    check_drained("wrap");

    // zero-length frame is not accepted
    start_frame(24'h004000, 0);
    @(posedge clk); #1;
    chk("zero_busy", busy, 0);

    // reset mid-burst with a concurrent ack
    mon_en = 0;
    ack_pct = 100;
    start_frame(24'h005000, 16);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid_cyc_seen", wb_cyc_o, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rstmid_wr_en", fifo_wr_en, 0);
    chk("rstmid_cyc", wb_cyc_o, 0);
    chk("rstmid_busy", busy, 0);
    @(posedge clk); #1;
    chk("rstmid_wr_en2", fifo_wr_en, 0);
    chk("rstmid_cyc2", wb_cyc_o, 0);
    mon_en = 1;

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      ack_pct    = $urandom_range(40, 100);
      fifo_level = 7'($urandom_range(0, 56));
      b          = AW'($urandom);
      w          = $urandom_range(1, 40);
      plan_frame(b, w);
      start_frame(b, w);
      wait_idle("rand", 3000);
      check_drained("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_fetch_master.md
FB_FETCH_MASTER -- requirements
Module: fb_fetch_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning Wishbone and FIFO data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, meaning Wishbone word-address width.
REQ-003 SHALL have parameter BURST_LEN, default 8, meaning maximum words per Wishbone cycle (power of 2, >=2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, meaning capacity of the downstream sync FIFO.
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse that starts a frame fetch.
REQ-008 SHALL have port base_addr  in  ADDR_WIDTH  first word address of the frame, sampled on frame acceptance.
REQ-009 SHALL have port frame_words  in  ADDR_WIDTH  words per frame, sampled on frame acceptance; 0 means no fetch.
REQ-010 SHALL have ports wb_adr_o out ADDR_WIDTH, wb_cyc_o out 1, wb_stb_o out 1, wb_cti_o out 3, with Wishbone master meaning.
REQ-011 SHALL have ports wb_dat_i in DATA_WIDTH, wb_ack_i in 1, wb_err_i in 1, with Wishbone master meaning.
REQ-012 SHALL have port fifo_data  out  DATA_WIDTH  write data to the FIFO.
REQ-013 SHALL have port fifo_wr_en  out  1  FIFO write strobe.
REQ-014 SHALL have port fifo_level  in  clog2(FIFO_DEPTH)+1  FIFO status count.
REQ-015 SHALL have ports busy out 1 (frame in progress) and err out 1 (sticky bus error).

Function
REQ-016 SHALL implement states IDLE, CHECK, BURST.
REQ-017 IDLE: on frame_start with frame_words!=0, SHALL latch base_addr/frame_words into addr/remaining and go to CHECK; busy=1 from the next cycle.
REQ-018 CHECK: SHALL compute len=min(BURST_LEN, remaining) and go to BURST only when FIFO_DEPTH-(fifo_level+fifo_wr_en)>=len; otherwise stay.
REQ-019 BURST: SHALL hold wb_cyc_o=wb_stb_o=1 and wb_adr_o=addr, incrementing addr by 1 on each wb_ack_i.
REQ-020 SHALL register each acked word: fifo_data=wb_dat_i and fifo_wr_en=1 exactly one cycle after wb_ack_i; never otherwise.
REQ-021 SHALL deassert wb_cyc_o/wb_stb_o in the cycle after the len-th ack and decrement remaining by len.
REQ-022 After a burst, SHALL go to CHECK if remaining!=0, else IDLE with busy=0.
REQ-023 addr SHALL wrap modulo 2^ADDR_WIDTH; no other address checking.
REQ-024 frame_start during CHECK SHALL restart immediately from new base_addr/frame_words.
REQ-025 frame_start during BURST SHALL be latched as pending; the current burst completes, then the fetch restarts with values sampled at the pulse.
REQ-026 frame_start coinciding with the final ack of a frame SHALL restart, not go IDLE.
REQ-027 wb_err_i during BURST SHALL end the cycle next clock, write nothing for that beat, set err=1, go IDLE; err clears only on the next accepted frame_start or rst.
REQ-028 wb_ack_i and wb_err_i outside BURST SHALL be ignored.

Reset
REQ-029 On rst, SHALL go to IDLE, clear pending, and drive wb_cyc_o=0, wb_stb_o=0, wb_cti_o=0, wb_adr_o=0, fifo_wr_en=0, fifo_data=0, busy=0, err=0.
REQ-030 rst mid-burst SHALL drop wb_cyc_o in the following cycle with no FIFO write for any concurrent ack.

Configuration
REQ-031 With macro FB_FETCH_CTI_EN defined, SHALL drive wb_cti_o=3'b010 for every beat but the last, and 3'b111 on the last beat of each burst.
REQ-032 Without FB_FETCH_CTI_EN, SHALL drive wb_cti_o=3'b000 (classic) at all times; all other behaviour identical.

Verification
REQ-033 frame_words=20, BURST_LEN=8, fifo_level=0, ack every cycle -> bursts of 8, 8, 4; 20 FIFO writes in address order from base_addr; busy falls after the last.
REQ-034 fifo_level=60, FIFO_DEPTH=64 -> stays in CHECK, no wb_cyc_o; level drops to 56 -> burst starts next cycle.
REQ-035 wb_err_i on beat 3 of the first burst -> 2 FIFO writes, wb_cyc_o low next cycle, err=1, IDLE; next frame_start clears err.
REQ-036 frame_start mid-burst with new base_addr=0x100 -> current burst finishes, next wb_adr_o=0x100.
REQ-037 base_addr=0xFFFFFE, frame_words=4 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-038 With FB_FETCH_CTI_EN, 8-beat burst -> wb_cti_o=010 for seven beats, 111 on beat 8; without it, 000 throughout.
